control_sequencer: RTL and testbench

- Hardwired control unit that drives the existing Datapath's bus and register control strobes, replacing hand-sequenced stimulus.
- Steps each instruction through fetch (T0-T2) and opcode-dependent execute steps (T3-T6), using a Read/mem_rdy handshake on instruction fetch.
- Sits beside Datapath and takes IR from it.
- Register-file selection uses Gra/Grb/Grc with Rin/Rout (select-and-encode), so no per-register strobes leave this block.

---
 rtl/control_sequencer_pkg.sv | 87 ++++++++
 rtl/ctrl_signal_decode.sv | 136 +++++++++++++
 rtl/control_sequencer.sv | 113 +++++++++++
 tb/tb_control_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcode encodings,
// sequencer states, ALU function codes and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_WIDTH    = 5;
  localparam int unsigned ALU_OP_WIDTH = 4;

  // Instruction opcodes, IR[31:27]
  localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_WIDTH-1:0] OP_AND  = 5'b00010;
  localparam logic [OPC_WIDTH-1:0] OP_OR   = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OP_SHR  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OP_SHL  = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OP_MUL  = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OP_DIV  = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OP_MFHI = 5'b01010;
  localparam logic [OPC_WIDTH-1:0] OP_MFLO = 5'b01011;
  localparam logic [OPC_WIDTH-1:0] OP_NOP  = 5'b01100;
  localparam logic [OPC_WIDTH-1:0] OP_HALT = 5'b01101;

  // ALU function codes
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV = 4'd7;

  // Sequencer states; the encoding is visible on the debug state port
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T1W    = 4'd3,
    ST_T2     = 4'd4,
    ST_T3     = 4'd5,
    ST_T4     = 4'd6,
    ST_T5     = 4'd7,
    ST_T6     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

  // Execute-phase behaviour groups
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_MFHI    = 3'd2,
    CLS_MFLO    = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_e;

  function automatic op_class_e classify(input logic [OPC_WIDTH-1:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: cls = CLS_ALU;
      OP_MUL, OP_DIV:                                 cls = CLS_MULDIV;
      OP_MFHI:                                        cls = CLS_MFHI;
      OP_MFLO:                                        cls = CLS_MFLO;
      OP_NOP:                                         cls = CLS_NOP;
      OP_HALT:                                        cls = CLS_HALT;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [ALU_OP_WIDTH-1:0] alu_code(input logic [OPC_WIDTH-1:0] op);
    logic [ALU_OP_WIDTH-1:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SHR:  code = ALU_SHR;
      OP_SHL:  code = ALU_SHL;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_signal_decode.sv
// Combinational strobe decoder: maps the registered sequencer state and the
// current opcode onto every datapath control strobe and the ALU function.
module ctrl_signal_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W    = OPC_WIDTH,
  parameter int unsigned ALU_OP_W = ALU_OP_WIDTH
) (
  input  state_e              state,
  input  logic [OPC_W-1:0]    opcode,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic                halted
);

  op_class_e cls;

  // Strobes per state; everything not named for a state stays low
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = '0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    cls        = classify(opcode);

    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_MFHI: begin
            HIout = 1'b1;
            Gra   = 1'b1;
            Rin   = 1'b1;
          end
          CLS_MFLO: begin
            LOout = 1'b1;
            Gra   = 1'b1;
            Rin   = 1'b1;
          end
          CLS_ILLEGAL: illegal_op = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        if (cls == CLS_ALU || cls == CLS_MULDIV) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          alu_op = alu_code(opcode);
        end
      end
      ST_T5: begin
        if (cls == CLS_ALU) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: holds the fetch/execute state register and the
// next-state logic; strobes come from ctrl_signal_decode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W    = OPC_WIDTH,
  parameter int unsigned ALU_OP_W = ALU_OP_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         IR,
  input  logic                mem_rdy,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic                halted,
  output logic [3:0]          state
);

  state_e           state_q;
  state_e           state_d;
  logic [OPC_W-1:0] opcode;
  op_class_e        cls;
  logic             unused_ir_bits;

  assign opcode         = IR[31 -: OPC_W];
  assign unused_ir_bits = ^IR[31-OPC_W:0];
  assign cls            = classify(opcode);
  assign state          = state_q;

  // State register; reset overrides every transition including HALTED
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: fixed fetch, then opcode-dependent execute length
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = mem_rdy ? ST_T2 : ST_T1W;
      ST_T1W:  state_d = mem_rdy ? ST_T2 : ST_T1W;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: state_d = ST_T4;
          CLS_HALT:            state_d = ST_HALTED;
          default:             state_d = ST_T0;
        endcase
      end
      ST_T4:     state_d = ST_T5;
      ST_T5:     state_d = (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:     state_d = ST_T0;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  ctrl_signal_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .PCout      (PCout),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .MDRout     (MDRout),
    .HIout      (HIout),
    .LOout      (LOout),
    .MARin      (MARin),
    .Zin        (Zin),
    .PCin       (PCin),
    .MDRin      (MDRin),
    .IRin       (IRin),
    .Yin        (Yin),
    .HIin       (HIin),
    .LOin       (LOin),
    .IncPC      (IncPC),
    .Read       (Read),
    .Gra        (Gra),
    .Grb        (Grb),
    .Grc        (Grc),
    .Rin        (Rin),
    .Rout       (Rout),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .halted     (halted)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction reference model
// expands each instruction into its expected cycle-by-cycle strobe sets.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b1;
  logic        reset;
  logic        mem_rdy;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [3:0] alu_op;
  logic illegal_op, halted;
  logic [3:0] state;

  always #5 clk = ~clk;

  control_sequencer #(.OPC_W(5), .ALU_OP_W(4)) dut (
    .clk(clk), .reset(reset), .IR(IR), .mem_rdy(mem_rdy),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .illegal_op(illegal_op),
    .halted(halted), .state(state)
  );

  // Strobe bundle, one bit per output
  localparam logic [22:0] S_PCOUT = 23'd1 << 22, S_ZLOW  = 23'd1 << 21,
                          S_ZHIGH = 23'd1 << 20, S_MDROUT = 23'd1 << 19,
                          S_HIOUT = 23'd1 << 18, S_LOOUT = 23'd1 << 17,
                          S_MARIN = 23'd1 << 16, S_ZIN   = 23'd1 << 15,
                          S_PCIN  = 23'd1 << 14, S_MDRIN = 23'd1 << 13,
                          S_IRIN  = 23'd1 << 12, S_YIN   = 23'd1 << 11,
                          S_HIIN  = 23'd1 << 10, S_LOIN  = 23'd1 << 9,
                          S_INCPC = 23'd1 << 8,  S_READ  = 23'd1 << 7,
                          S_GRA   = 23'd1 << 6,  S_GRB   = 23'd1 << 5,
                          S_GRC   = 23'd1 << 4,  S_RIN   = 23'd1 << 3,
                          S_ROUT  = 23'd1 << 2,  S_ILL   = 23'd1 << 1,
                          S_HALT  = 23'd1 << 0;
  localparam logic [22:0] BUS_MASK = S_PCOUT | S_ZLOW | S_ZHIGH | S_MDROUT |
                                     S_HIOUT | S_LOOUT | S_ROUT;

  logic [22:0] dut_vec;
  assign dut_vec = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, MARin, Zin,
                    PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, Gra, Grb,
                    Grc, Rin, Rout, illegal_op, halted};

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] ir;
    logic        chk;
    logic [3:0]  st;
    logic [22:0] strb;
    logic [3:0]  aop;
  } cyc_t;

  cyc_t stim_q[$];
  cyc_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  function automatic cyc_t mk(input state_e st, input logic [22:0] strb,
                              input logic [3:0] aop, input logic [31:0] ir);
    cyc_t r;
    r.rst  = 1'b0;
    r.rdy  = 1'($urandom_range(0, 1));
    r.ir   = ir;
    r.chk  = 1'b1;
    r.st   = st;
    r.strb = strb;
    r.aop  = aop;
    return r;
  endfunction

  // Reference model: expand one instruction into its expected cycles.
  // abort truncates the sequence with reset at cycle index abort_sel % length.
  task automatic gen_instr(input logic [31:0] ir, input int unsigned stalls,
                           input bit abort, input int unsigned abort_sel);
    cyc_t        cur[$];
    cyc_t        r;
    logic [4:0]  op;
    logic [3:0]  aop;
    bit          is_alu, is_md, is_halt;
    int unsigned idx;
    op      = ir[31:27];
    is_alu  = (op <= 5);
    is_md   = (op == 8) || (op == 9);
    is_halt = (op == 13);
    cur.push_back(mk(ST_T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 4'd0, ir));
    r = mk(ST_T1, S_ZLOW | S_PCIN | S_READ | S_MDRIN, 4'd0, ir);
    r.rdy = (stalls == 0);
    cur.push_back(r);
    for (int unsigned i = 0; i < stalls; i++) begin
      r = mk(ST_T1W, S_READ | S_MDRIN, 4'd0, ir);
      r.rdy = (i == stalls - 1);
      cur.push_back(r);
    end
    cur.push_back(mk(ST_T2, S_MDROUT | S_IRIN, 4'd0, ir));
    if (is_alu || is_md) begin
      aop = is_alu ? 4'(op) : ((op == 8) ? 4'd6 : 4'd7);
      cur.push_back(mk(ST_T3, S_GRB | S_ROUT | S_YIN, 4'd0, ir));
      cur.push_back(mk(ST_T4, S_GRC | S_ROUT | S_ZIN, aop, ir));
      if (is_alu) cur.push_back(mk(ST_T5, S_ZLOW | S_GRA | S_RIN, 4'd0, ir));
      else begin
        cur.push_back(mk(ST_T5, S_ZLOW | S_LOIN, 4'd0, ir));
        cur.push_back(mk(ST_T6, S_ZHIGH | S_HIIN, 4'd0, ir));
      end
    end else if (op == 10) cur.push_back(mk(ST_T3, S_HIOUT | S_GRA | S_RIN, 4'd0, ir));
    else if (op == 11)     cur.push_back(mk(ST_T3, S_LOOUT | S_GRA | S_RIN, 4'd0, ir));
    else if (op == 12)     cur.push_back(mk(ST_T3, 23'd0, 4'd0, ir));
    else if (is_halt) begin
      cur.push_back(mk(ST_T3, 23'd0, 4'd0, ir));
      repeat (20) cur.push_back(mk(ST_HALTED, S_HALT, 4'd0, ir));
    end else cur.push_back(mk(ST_T3, S_ILL, 4'd0, ir));

    if (is_halt) begin
      cur[cur.size()-1].rst = 1'b1;
      cur.push_back(mk(ST_IDLE, 23'd0, 4'd0, ir));
    end else if (abort) begin
      idx = abort_sel % cur.size();
      while (cur.size() > idx + 1) void'(cur.pop_back());
      cur[idx].rst = 1'b1;
      cur.push_back(mk(ST_IDLE, 23'd0, 4'd0, ir));
    end
    foreach (cur[i]) stim_q.push_back(cur[i]);
  endtask

  // Monitor: compare every sampled cycle against the scoreboard head
  always @(negedge clk) begin
    cyc_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        vectors++;
        if (state !== e.st || dut_vec !== e.strb || alu_op !== e.aop) begin
          miscompares++;
          $display("FAIL cycle%0d outputs: got state=%0d strobes=%h alu_op=%0d, want state=%0d strobes=%h alu_op=%0d",
                   cyc, state, dut_vec, alu_op, e.st, e.strb, e.aop);
        end
        vectors++;
        if ($countones(dut_vec & BUS_MASK) > 1) begin
          miscompares++;
          $display("FAIL cycle%0d bus_onehot: got drivers=%h, want at most one", cyc, dut_vec & BUS_MASK);
        end
        if (Rin || Rout) begin
          vectors++;
          if ($countones({Gra, Grb, Grc}) != 1) begin
            miscompares++;
            $display("FAIL cycle%0d reg_select: got Gra/Grb/Grc=%b, want exactly one", cyc, {Gra, Grb, Grc});
          end
        end
      end
    end
    cyc++;
  end

  // Stimulus generation and driver
  initial begin
    cyc_t        r;
    logic [31:0] rnd;
    logic [4:0]  op;
    reset = 1'b1; mem_rdy = 1'b0; IR = '0;

    r = mk(ST_IDLE, 23'd0, 4'd0, 32'd0); r.rst = 1'b1; r.chk = 1'b0; stim_q.push_back(r);
    r = mk(ST_IDLE, 23'd0, 4'd0, 32'd0); r.rst = 1'b1; stim_q.push_back(r);
    stim_q.push_back(mk(ST_IDLE, 23'd0, 4'd0, 32'd0));

    gen_instr(32'h00920000, 0, 1'b0, 0);   // ADD
    gen_instr(32'h4A920000, 0, 1'b0, 0);   // DIV
    gen_instr(32'h08920000, 3, 1'b0, 0);   // SUB with fetch wait
    gen_instr(32'hF8000000, 0, 1'b0, 0);   // illegal 11111
    gen_instr(32'h40920000, 0, 1'b1, 4);   // MUL reset in T4
    gen_instr(32'h68000000, 0, 1'b0, 0);   // HALT
    gen_instr(32'h50000000, 1, 1'b0, 0);   // MFHI
    gen_instr(32'h58000000, 0, 1'b0, 0);   // MFLO
    gen_instr(32'h60000000, 2, 1'b0, 0);   // NOP

    for (int i = 0; i < 150; i++) begin
      rnd = $urandom();
      if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 13));
      else                           op = 5'($urandom_range(0, 31));
      rnd[31:27] = op;
      gen_instr(rnd, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 9) == 0), $urandom());
    end

    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      reset   = r.rst;
      mem_rdy = r.rdy;
      IR      = r.ir;
      sb_q.push_back(r);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
